// File: rtl/wb_gateway_arbiter.sv
// Two-master Wishbone arbiter in front of the single NoC gateway slave port.
// The loader has strict priority until boot_done; after that, masters alternate round-robin.

module wb_gateway_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          boot_done,

  input  logic          m0_cyc,
  input  logic          m0_stb,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_adr,
  input  logic [DW-1:0] m0_dat,
  output logic          m0_ack,
  output logic          m0_err,

  input  logic          m1_cyc,
  input  logic          m1_stb,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_adr,
  input  logic [DW-1:0] m1_dat,
  output logic          m1_ack,
  output logic          m1_err,

  output logic          s_cyc,
  output logic          s_stb,
  output logic          s_we,
  output logic [AW-1:0] s_adr,
  output logic [DW-1:0] s_dat,
  input  logic          s_ack,

  output logic [1:0]    gnt,
  output logic          timeout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS0 = 2'd1,
    BUS1 = 2'd2
  } state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
  localparam logic [TO_W-1:0] TO_MAX  = '1;

  state_t          state_q;
  logic            last_q;
  logic [TO_W-1:0] to_cnt_q;
  logic [1:0]      err_q;
  logic            timeout_q;

  logic            busy;
  logic            sel_cyc;
  logic            sel_stb;
  logic            sel_we;
  logic [AW-1:0]   sel_adr;
  logic [DW-1:0]   sel_dat;
  logic            stall;

  // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    busy    = 1'b0;
    sel_cyc = 1'b0;
    sel_stb = 1'b0;
    sel_we  = 1'b0;
    sel_adr = '0;
    sel_dat = '0;
    case (state_q)
      BUS0: begin
        busy    = 1'b1;
        sel_cyc = m0_cyc;
        sel_stb = m0_stb;
        sel_we  = m0_we;
        sel_adr = m0_adr;
        sel_dat = m0_dat;
      end
      BUS1: begin
        busy    = 1'b1;
        sel_cyc = m1_cyc;
        sel_stb = m1_stb;
        sel_we  = m1_we;
        sel_adr = m1_adr;
        sel_dat = m1_dat;
      end
      default: ;
    endcase
  end

  assign s_cyc   = sel_cyc;
  assign s_stb   = sel_stb;
  assign s_we    = sel_we;
  assign s_adr   = sel_adr;
  assign s_dat   = sel_dat;

  // An ack seen in IDLE is dropped here because neither grant qualifies it.
  assign m0_ack  = (state_q == BUS0) && s_ack;
  assign m1_ack  = (state_q == BUS1) && s_ack;
  assign m0_err  = err_q[0];
  assign m1_err  = err_q[1];
  assign timeout = timeout_q;
  assign gnt     = {state_q == BUS1, state_q == BUS0};

  assign stall   = busy && sel_cyc && sel_stb && !s_ack;

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      to_cnt_q  <= '0;
      err_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      err_q     <= '0;
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          to_cnt_q <= '0;
          if (!boot_done) begin
            if (m0_cyc) state_q <= BUS0;
          end else if (m0_cyc && m1_cyc) begin
            state_q <= last_q ? BUS0 : BUS1;
          end else if (m0_cyc) begin
            state_q <= BUS0;
          end else if (m1_cyc) begin
            state_q <= BUS1;
          end
        end
        BUS0, BUS1: begin
          if (!sel_cyc) begin
            state_q  <= IDLE;
            last_q   <= (state_q == BUS1);
            to_cnt_q <= '0;
          end else if (stall && (to_cnt_q == TO_LAST)) begin
            // Abort: the error pulse and the bus release land in the same cycle.
            state_q   <= IDLE;
            last_q    <= (state_q == BUS1);
            to_cnt_q  <= '0;
            err_q     <= {state_q == BUS1, state_q == BUS0};
            timeout_q <= 1'b1;
          end else if (stall) begin
            if (to_cnt_q != TO_MAX) to_cnt_q <= to_cnt_q + 1'b1;
          end else begin
            to_cnt_q <= '0;
          end
        end
        default: begin
          state_q  <= IDLE;
          to_cnt_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_gateway_arbiter.sv
// Directed bench for wb_gateway_arbiter: boot priority, round-robin, routing, timeout, reset.
// Status vector st = {gnt[1:0], s_cyc, m0_ack, m1_ack, m0_err, m1_err, timeout}.

module tb_wb_gateway_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          boot_done;
  logic          m0_cyc, m0_stb, m0_we;
  logic [AW-1:0] m0_adr;
  logic [DW-1:0] m0_dat;
  logic          m0_ack, m0_err;
  logic          m1_cyc, m1_stb, m1_we;
  logic [AW-1:0] m1_adr;
  logic [DW-1:0] m1_dat;
  logic          m1_ack, m1_err;
  logic          s_cyc, s_stb, s_we;
  logic [AW-1:0] s_adr;
  logic [DW-1:0] s_dat;
  logic          s_ack;
  logic [1:0]    gnt;
  logic          timeout;
  logic [7:0]    st;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign st = {gnt, s_cyc, m0_ack, m1_ack, m0_err, m1_err, timeout};

  wb_gateway_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(4), .TO_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .boot_done(boot_done),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr), .m0_dat(m0_dat),
    .m0_ack(m0_ack), .m0_err(m0_err),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr), .m1_dat(m1_dat),
    .m1_ack(m1_ack), .m1_err(m1_err),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_dat(s_dat), .s_ack(s_ack),
    .gnt(gnt), .timeout(timeout)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; boot_done = 1'b0; s_ack = 1'b1;
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b1; m0_adr = 32'hA5A5_0000; m0_dat = 32'h1234_5678;
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = 1'b1; m1_adr = 32'h5A5A_0000; m1_dat = 32'h8765_4321;
    #3;
    n_cmp++;
    if (st !== 8'h00) begin n_bad++; $display("FAIL reset_status: got %b want %b", st, 8'h00); end
    n_cmp++;
    if ({s_stb, s_we, s_adr, s_dat} !== '0) begin
      n_bad++; $display("FAIL reset_bus: got stb=%b we=%b adr=%h dat=%h want all 0", s_stb, s_we, s_adr, s_dat);
    end
    m0_cyc = 1'b0; m0_stb = 1'b0; m0_we = 1'b0;
    m1_cyc = 1'b0; m1_stb = 1'b0; m1_we = 1'b0;
    s_ack = 1'b0;
    #9 rst_n = 1'b1;
    step();
    n_cmp++;
    if (st !== 8'h00) begin n_bad++; $display("FAIL reset_idle: got %b want %b", st, 8'h00); end
  endtask

  task automatic test_boot_priority();
    boot_done = 1'b0;
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b0; m0_adr = 32'h100; m0_dat = 32'h11;
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = 1'b1; m1_adr = 32'h200; m1_dat = 32'h22;
    #1;
    n_cmp++;
    if (st !== 8'h00) begin n_bad++; $display("FAIL boot_req_cycle: got %b want %b", st, 8'h00); end
    step();
    n_cmp++;
    if (st !== 8'b01_1_0_0_000) begin n_bad++; $display("FAIL boot_gnt0: got %b want %b", st, 8'b01_1_0_0_000); end
    n_cmp++;
    if (s_adr !== 32'h100 || s_we !== 1'b0) begin
      n_bad++; $display("FAIL boot_route0: got adr=%h we=%b want adr=100 we=0", s_adr, s_we);
    end
    s_ack = 1'b1; #1;
    n_cmp++;
    if (st !== 8'b01_1_1_0_000) begin n_bad++; $display("FAIL boot_ack0: got %b want %b", st, 8'b01_1_1_0_000); end
    step();
    s_ack = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0; boot_done = 1'b1; #1;
    n_cmp++;
    if (st !== 8'b01_0_0_0_000) begin n_bad++; $display("FAIL boot_release: got %b want %b", st, 8'b01_0_0_0_000); end
    step();
    n_cmp++;
    if (st !== 8'h00) begin n_bad++; $display("FAIL boot_gap: got %b want %b", st, 8'h00); end
    step();
    n_cmp++;
    if (st !== 8'b10_1_0_0_000) begin n_bad++; $display("FAIL boot_gnt1: got %b want %b", st, 8'b10_1_0_0_000); end
    n_cmp++;
    if (s_adr !== 32'h200 || s_we !== 1'b1) begin
      n_bad++; $display("FAIL boot_route1: got adr=%h we=%b want adr=200 we=1", s_adr, s_we);
    end
    s_ack = 1'b1; #1;
    n_cmp++;
    if (st !== 8'b10_1_0_1_000) begin n_bad++; $display("FAIL boot_ack1: got %b want %b", st, 8'b10_1_0_1_000); end
    step();
    s_ack = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
    step();
  endtask

  // Precondition: current cycle is IDLE with both masters requesting; ends in the next IDLE cycle.
  task automatic rr_grant(input logic [1:0] exp);
    #1;
    n_cmp++;
    if (st !== 8'h00) begin n_bad++; $display("FAIL rr_gap: got %b want %b", st, 8'h00); end
    step();
    n_cmp++;
    if (st !== {exp, 6'b1_0_0_000}) begin n_bad++; $display("FAIL rr_gnt: got %b want %b", st, {exp, 6'b1_0_0_000}); end
    step();
    s_ack = 1'b1; #1;
    n_cmp++;
    if (st !== {exp, 1'b1, exp[0], exp[1], 3'b000}) begin
      n_bad++; $display("FAIL rr_ack: got %b want %b", st, {exp, 1'b1, exp[0], exp[1], 3'b000});
    end
    step();
    s_ack = 1'b0;
    if (exp[0]) begin m0_cyc = 1'b0; m0_stb = 1'b0; end
    else        begin m1_cyc = 1'b0; m1_stb = 1'b0; end
    #1;
    n_cmp++;
    if (st !== {exp, 6'b0_0_0_000}) begin n_bad++; $display("FAIL rr_hold: got %b want %b", st, {exp, 6'b0_0_0_000}); end
    step();
  endtask

  task automatic test_round_robin();
    logic [1:0] seq [3];
    seq[0] = 2'b01; seq[1] = 2'b10; seq[2] = 2'b01;
    boot_done = 1'b1;
    m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rr_grant(seq[i]);
      m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
    end
    m0_cyc = 1'b0; m0_stb = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
    step();
  endtask

  task automatic test_write_route();
    m0_adr = 32'h55; m0_dat = 32'h0; m0_we = 1'b0;
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = 1'b1; m1_adr = 32'h10; m1_dat = 32'hDEAD_BEEF;
    s_ack = 1'b1; #1;
    n_cmp++;
    if (st !== 8'h00) begin n_bad++; $display("FAIL idle_ack_dropped: got %b want %b", st, 8'h00); end
    step();
    s_ack = 1'b0; #1;
    n_cmp++;
    if (st !== 8'b10_1_0_0_000) begin n_bad++; $display("FAIL wr_gnt: got %b want %b", st, 8'b10_1_0_0_000); end
    n_cmp++;
    if (s_adr !== 32'h10 || s_dat !== 32'hDEAD_BEEF || s_we !== 1'b1 || s_stb !== 1'b1) begin
      n_bad++; $display("FAIL wr_route: got adr=%h dat=%h we=%b stb=%b want 10 deadbeef 1 1", s_adr, s_dat, s_we, s_stb);
    end
    s_ack = 1'b1; #1;
    n_cmp++;
    if (st !== 8'b10_1_0_1_000) begin n_bad++; $display("FAIL wr_ack: got %b want %b", st, 8'b10_1_0_1_000); end
    step();
    s_ack = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0; m1_we = 1'b0;
    step();
  endtask

  task automatic test_timeout();
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'h300;
    step();
    n_cmp++;
    if (st !== 8'b01_1_0_0_000) begin n_bad++; $display("FAIL to_gnt: got %b want %b", st, 8'b01_1_0_0_000); end
    m1_cyc = 1'b1; m1_stb = 1'b1;
    for (int i = 1; i < 4; i++) begin
      step();
      n_cmp++;
      if (st !== 8'b01_1_0_0_000) begin n_bad++; $display("FAIL to_wait%0d: got %b want %b", i, st, 8'b01_1_0_0_000); end
    end
    step();
    n_cmp++;
    if (st !== 8'b00_0_0_0_101) begin n_bad++; $display("FAIL to_abort: got %b want %b", st, 8'b00_0_0_0_101); end
    step();
    m0_cyc = 1'b0; m0_stb = 1'b0; #1;
    n_cmp++;
    if (st !== 8'b10_1_0_0_000) begin n_bad++; $display("FAIL to_handover: got %b want %b", st, 8'b10_1_0_0_000); end
    s_ack = 1'b1; #1;
    n_cmp++;
    if (st !== 8'b10_1_0_1_000) begin n_bad++; $display("FAIL to_m1_ack: got %b want %b", st, 8'b10_1_0_1_000); end
    step();
    s_ack = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
    step();
  endtask

  task automatic test_ack_at_threshold();
    m0_cyc = 1'b1; m0_stb = 1'b1;
    step();
    step();
    step();
    step();
    s_ack = 1'b1; #1;
    n_cmp++;
    if (st !== 8'b01_1_1_0_000) begin n_bad++; $display("FAIL thr_ack: got %b want %b", st, 8'b01_1_1_0_000); end
    step();
    s_ack = 1'b0; #1;
    n_cmp++;
    if (st !== 8'b01_1_0_0_000) begin n_bad++; $display("FAIL thr_hold: got %b want %b", st, 8'b01_1_0_0_000); end
    for (int i = 0; i < 2; i++) begin
      step();
      n_cmp++;
      if (st !== 8'b01_1_0_0_000) begin n_bad++; $display("FAIL thr_cleared%0d: got %b want %b", i, st, 8'b01_1_0_0_000); end
    end
    step();
    m0_cyc = 1'b0; m0_stb = 1'b0; #1;
    n_cmp++;
    if (st !== 8'b01_0_0_0_000) begin n_bad++; $display("FAIL thr_drop: got %b want %b", st, 8'b01_0_0_0_000); end
    step();
    n_cmp++;
    if (st !== 8'h00) begin n_bad++; $display("FAIL thr_exit_noerr: got %b want %b", st, 8'h00); end
  endtask

  task automatic test_reset_mid();
    boot_done = 1'b1;
    m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
    step();
    n_cmp++;
    if (st !== 8'b10_1_0_0_000) begin n_bad++; $display("FAIL rst_pre_gnt: got %b want %b", st, 8'b10_1_0_0_000); end
    s_ack = 1'b1; #1;
    rst_n = 1'b0; #1;
    n_cmp++;
    if (st !== 8'h00) begin n_bad++; $display("FAIL rst_async: got %b want %b", st, 8'h00); end
    step();
    #1 rst_n = 1'b1; s_ack = 1'b0;
    step();
    n_cmp++;
    if (st !== 8'b01_1_0_0_000) begin n_bad++; $display("FAIL rst_first_gnt: got %b want %b", st, 8'b01_1_0_0_000); end
    m0_cyc = 1'b0; m0_stb = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
    step();
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_boot_priority();
    test_round_robin();
    test_write_route();
    test_timeout();
    test_ack_at_threshold();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
